// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg : shared definitions for the Beta instruction fetch stage.
//   - PCSEL_* next-PC select encodings driven by decode/control
//   - default reset / illegal-op / exception vectors
//   - INST_NOP, the bubble presented to decode when no instruction is valid
//   - fetch_state_e, the single-outstanding fetch FSM states
//   - fetch_buf_entry_t, one {pc_plus_four, inst} slot of the optional buffer
//   - pc_inc(), PC increment that never carries into the supervisor bit
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // ADD(R31, R31, R31): writes the constant-zero register, i.e. no effect.
  localparam logic [31:0] INST_NOP = 32'h83FF_F800;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ppf;
    logic [31:0] inst;
  } fetch_buf_entry_t;

  // Bit 31 is the supervisor bit: the low 31 bits wrap without touching it.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf : 2-deep FIFO of fetched {pc_plus_four, inst} entries with flush.
// Only present when FETCH_BUF_EN is defined (it is instantiated by fetch only
// in that configuration).
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   flush_i      in   discard all entries (wins over push/pop)
//   push_i       in   write push_data_i at the tail
//   push_data_i  in   entry to write
//   pop_i        in   drop the head entry
//   head_o       out  oldest entry (valid when count_o != 0)
//   count_o      out  number of stored entries (0..2)
//
// The caller never pushes into a full buffer or pops an empty one.
// -----------------------------------------------------------------------------
`ifdef FETCH_BUF_EN
module fetch_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_buf_entry_t push_data_i,
  input  logic             pop_i,
  output fetch_buf_entry_t head_o,
  output logic [1:0]       count_o
);

  fetch_buf_entry_t mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (push_i && !flush_i && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`endif

// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch : instruction fetch stage of the Beta pipeline. Owns the PC, issues
// instruction-memory requests, applies redirects from decode/control and
// presents one instruction plus its PC+4 to decode.
//
// Configuration macro: FETCH_BUF_EN
//   undefined : single outstanding request, S_REQ/S_WAIT/S_HOLD FSM.
//   defined   : up to 2 outstanding requests feeding a 2-entry fetch_buf.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_sel[2:0]         next-PC select (PCSEL_*), sampled every cycle
//   branch_addr[31:0]   branch target
//   jump_addr[31:0]     jump target
//   stall               decode cannot accept a new instruction
//   imem_req/imem_addr  request valid / word-aligned request address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   in-order response, latency >= 1 after grant
//   inst/pc_plus_four   instruction to decode and its PC+4
//   inst_valid          inst holds a real instruction
// -----------------------------------------------------------------------------
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DEF_XADR_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_plus_four,
  output logic        inst_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ppf_q, ppf_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] next_pc;

  // Mode-specific logic offers an instruction to the output registers here.
  logic        load_en;
  logic [31:0] load_inst;
  logic [31:0] load_ppf;

  // Target alignment bits are forced to zero, so they are never read.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{branch_addr[1:0], jump_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Redirect target. A jump keeps supervisor mode only if the instruction in
  // decode already runs in supervisor mode, so jumps can never enter it.
  // Unused pc_sel encodings behave as increment.
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect = 1'b1;
    next_pc  = pc_q;
    case (pc_sel)
      PCSEL_BR:    next_pc = {branch_addr[31:2], 2'b00};
      PCSEL_JMP:   next_pc = {ppf_q[31] & jump_addr[31], jump_addr[30:2], 2'b00};
      PCSEL_ILLOP: next_pc = ILLOP_VEC;
      PCSEL_XADR:  next_pc = XADR_VEC;
      default:     redirect = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;

`ifdef FETCH_BUF_EN
  // ---------------------------------------------------------------------------
  // Buffered fetch: requests run ahead of decode until buffered entries plus
  // outstanding requests reach 2. A redirect flushes the buffer and turns every
  // outstanding request into one to be discarded on return.
  // ---------------------------------------------------------------------------
  fetch_buf_entry_t buf_head;
  fetch_buf_entry_t push_entry;
  logic [1:0]       buf_count;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic [1:0]       drop_cnt_q, drop_cnt_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [2:0]       inflight;
  logic             granted;
  logic             push;

  assign inflight   = {1'b0, buf_count} + {1'b0, out_cnt_q};
  assign imem_req   = rst_n & (drop_cnt_q == 2'd0) & (inflight < 3'd2);
  assign granted    = imem_req & imem_gnt;
  // Responses return in order, so the next live one belongs to resp_pc_q.
  assign push       = imem_rvalid & (drop_cnt_q == 2'd0) & ~redirect;
  assign push_entry = '{ppf: pc_inc(resp_pc_q), inst: imem_rdata};

  always_comb begin
    out_cnt_d = out_cnt_q + {1'b0, granted} - {1'b0, imem_rvalid};
    pc_d      = pc_q;
    if (redirect)     pc_d = next_pc;
    else if (granted) pc_d = pc_inc(pc_q);

    if (redirect) begin
      drop_cnt_d = out_cnt_d;
      resp_pc_d  = next_pc;
    end else begin
      drop_cnt_d = drop_cnt_q - {1'b0, imem_rvalid & (drop_cnt_q != 2'd0)};
      resp_pc_d  = push ? pc_inc(resp_pc_q) : resp_pc_q;
    end

    load_en   = (buf_count != 2'd0) & (~valid_q | ~stall) & ~redirect;
    load_inst = buf_head.inst;
    load_ppf  = buf_head.ppf;
  end

  fetch_buf u_fetch_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (load_en),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q  <= 2'd0;
      drop_cnt_q <= 2'd0;
      resp_pc_q  <= RESET_VEC;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      resp_pc_q  <= resp_pc_d;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single-outstanding fetch FSM.
  // ---------------------------------------------------------------------------
  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  hold_ppf_q, hold_ppf_d;
  logic         drop_q, drop_d;

  // Gated by rst_n so no request is visible while reset is asserted.
  assign imem_req = rst_n & (state_q == S_REQ);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    hold_inst_d = hold_inst_q;
    hold_ppf_d  = hold_ppf_q;
    drop_d      = drop_q;
    load_en     = 1'b0;
    load_inst   = imem_rdata;
    load_ppf    = pc_inc(fetch_pc_q);

    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          // A redirect in the grant cycle makes the granted fetch stale.
          fetch_pc_d = pc_q;
          pc_d       = redirect ? next_pc : pc_inc(pc_q);
          drop_d     = redirect;
          state_d    = S_WAIT;
        end else if (redirect) begin
          pc_d = next_pc;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          // If the stale response is arriving now it is simply discarded;
          // otherwise remember to discard it when it does arrive.
          pc_d = next_pc;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!valid_q || !stall) begin
            load_en = 1'b1;
          end else begin
            hold_inst_d = imem_rdata;
            hold_ppf_d  = pc_inc(fetch_pc_q);
            state_d     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          load_en   = 1'b1;
          load_inst = hold_inst_q;
          load_ppf  = hold_ppf_q;
          state_d   = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_VEC;
      hold_inst_q <= INST_NOP;
      hold_ppf_q  <= RESET_VEC + 32'd4;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_ppf_q  <= hold_ppf_d;
      drop_q      <= drop_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output registers. A redirect squashes whatever decode holds; otherwise an
  // unstalled decode consumes its instruction and sees a bubble unless a new
  // one loads in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_d  = inst_q;
    ppf_d   = ppf_q;
    valid_d = valid_q;
    if (redirect) begin
      inst_d  = INST_NOP;
      valid_d = 1'b0;
    end else if (load_en) begin
      inst_d  = load_inst;
      ppf_d   = load_ppf;
      valid_d = 1'b1;
    end else if (!stall) begin
      inst_d  = INST_NOP;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      inst_q  <= INST_NOP;
      ppf_q   <= RESET_VEC + 32'd4;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ppf_q   <= ppf_d;
      valid_q <= valid_d;
    end
  end

  assign inst         = inst_q;
  assign pc_plus_four = ppf_q;
  assign inst_valid   = valid_q;

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch : directed, table-driven bench for the fetch stage (default build).
// Instruction memory is modelled with a configurable grant-to-response latency;
// the word at address a is a ^ 32'h5A5A_A5A5.
// -----------------------------------------------------------------------------
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  pc_sel = PCSEL_INC;
  logic [31:0] branch_addr = '0;
  logic [31:0] jump_addr = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc_plus_four;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_sel       (pc_sel),
    .branch_addr  (branch_addr),
    .jump_addr    (jump_addr),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .pc_plus_four (pc_plus_four),
    .inst_valid   (inst_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // PC of the instruction whose PC+4 is ppf (supervisor bit unaffected).
  function automatic logic [31:0] pc_of(input logic [31:0] ppf);
    return {ppf[31], ppf[30:0] - 31'd4};
  endfunction

  // ---------------- memory model ----------------
  int unsigned lat = 1;
  logic        pend_q;
  logic [31:0] pend_addr_q;
  int unsigned pend_cnt_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_cnt_q  <= 0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend_q) begin
        if (pend_cnt_q <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(pend_addr_q);
          pend_q      <= 1'b0;
        end else begin
          pend_cnt_q <= pend_cnt_q - 1;
        end
      end
      if (imem_req && imem_gnt) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          pend_q      <= 1'b1;
          pend_cnt_q  <= lat - 1;
          pend_addr_q <= imem_addr;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] br;
    logic [31:0] jmp;
    logic        stl;
    logic        gnt;
    int unsigned lt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ppf;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];

  function automatic vec_t v(input logic [2:0] sel, input logic [31:0] br,
                             input logic [31:0] jmp, input logic stl, input logic gnt,
                             input int unsigned lt, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep);
    vec_t r;
    r.sel = sel; r.br = br; r.jmp = jmp; r.stl = stl; r.gnt = gnt; r.lt = lt;
    r.exp_req = er; r.exp_addr = ea; r.exp_valid = ev; r.exp_ppf = ep;
    return r;
  endfunction

  initial begin
    logic found;

    // Sequential fetch from reset, 1-cycle memory.
    vecs[0]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_0004, 0, 0);
    vecs[1]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0004, 1, 32'h8000_0004);
    vecs[2]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_0008, 0, 0);
    vecs[3]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0008, 1, 32'h8000_0008);
    vecs[4]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_000C, 0, 0);
    vecs[5]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_000C, 1, 32'h8000_000C);
    // Stall 3 cycles while the next response returns; then the held one.
    vecs[6]  = v(PCSEL_INC,   0, 0, 1, 1, 1, 0, 32'h8000_0010, 1, 32'h8000_000C);
    vecs[7]  = v(PCSEL_INC,   0, 0, 1, 1, 1, 0, 32'h8000_0010, 1, 32'h8000_000C);
    vecs[8]  = v(PCSEL_INC,   0, 0, 1, 1, 1, 0, 32'h8000_0010, 1, 32'h8000_000C);
    vecs[9]  = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0010, 1, 32'h8000_0010);
    // Slow response (3 cycles), branch while waiting: response dropped.
    vecs[10] = v(PCSEL_INC,   0, 0, 0, 1, 3, 0, 32'h8000_0014, 0, 0);
    vecs[11] = v(PCSEL_BR, 32'h8000_0100, 0, 0, 1, 3, 0, 32'h8000_0100, 0, 0);
    vecs[12] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_0100, 0, 0);
    vecs[13] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0100, 0, 0);
    vecs[14] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_0104, 0, 0);
    vecs[15] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0104, 1, 32'h8000_0104);
    // Branch into user mode in a grant cycle.
    vecs[16] = v(PCSEL_BR, 32'h0000_0100, 0, 0, 1, 1, 0, 32'h0000_0100, 0, 0);
    vecs[17] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h0000_0100, 0, 0);
    vecs[18] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h0000_0104, 0, 0);
    vecs[19] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h0000_0104, 1, 32'h0000_0104);
    // User-mode jump cannot set the supervisor bit.
    vecs[20] = v(PCSEL_JMP, 0, 32'h8000_1003, 0, 1, 1, 0, 32'h0000_1000, 0, 0);
    vecs[21] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h0000_1000, 0, 0);
    vecs[22] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h0000_1004, 0, 0);
    vecs[23] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h0000_1004, 1, 32'h0000_1004);
    // Illegal-op trap from user mode.
    vecs[24] = v(PCSEL_ILLOP, 0, 0, 0, 1, 1, 0, 32'h8000_0004, 0, 0);
    vecs[25] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0004, 0, 0);
    vecs[26] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_0008, 0, 0);
    vecs[27] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0008, 1, 32'h8000_0008);
    // Low 31 bits wrap, supervisor bit stays 0.
    vecs[28] = v(PCSEL_BR, 32'h7FFF_FFFC, 0, 0, 1, 1, 0, 32'h7FFF_FFFC, 0, 0);
    vecs[29] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h7FFF_FFFC, 0, 0);
    vecs[30] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h0000_0000, 0, 0);
    vecs[31] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h0000_0000, 1, 32'h0000_0000);
    // Exception vector, then redirect without grant.
    vecs[32] = v(PCSEL_XADR,  0, 0, 0, 1, 1, 0, 32'h8000_0008, 0, 0);
    vecs[33] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0008, 0, 0);
    vecs[34] = v(PCSEL_INC,   0, 0, 0, 0, 1, 1, 32'h8000_0008, 0, 0);
    vecs[35] = v(PCSEL_BR, 32'h8000_0203, 0, 0, 0, 1, 1, 32'h8000_0200, 0, 0);
    vecs[36] = v(PCSEL_INC,   0, 0, 0, 1, 1, 0, 32'h8000_0204, 0, 0);
    vecs[37] = v(PCSEL_INC,   0, 0, 0, 1, 1, 1, 32'h8000_0204, 1, 32'h8000_0204);

    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h8000_0000);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",  inst, INST_NOP);
    check("rst_ppf",   pc_plus_four, 32'h8000_0004);
    rst_n = 1'b1;
    #1;
    check("rel_req", {31'd0, imem_req}, 32'd1);

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      pc_sel      = vecs[i].sel;
      branch_addr = vecs[i].br;
      jump_addr   = vecs[i].jmp;
      stall       = vecs[i].stl;
      imem_gnt    = vecs[i].gnt;
      lat         = vecs[i].lt;
      @(posedge clk);
      #1;
      $display("row %0d: req=%0d addr=%08h valid=%0d ppf=%08h inst=%08h",
               i, imem_req, imem_addr, inst_valid, pc_plus_four, inst);
      check($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("row%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("row%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("row%0d_ppf", i), pc_plus_four, vecs[i].exp_ppf);
        check($sformatf("row%0d_inst", i), inst, mem_word(pc_of(vecs[i].exp_ppf)));
      end else begin
        check($sformatf("row%0d_inst", i), inst, INST_NOP);
      end
    end

    // ---------------- async reset in S_WAIT ----------------
    pc_sel = PCSEL_INC; stall = 1'b0; imem_gnt = 1'b1; lat = 3;
    @(posedge clk);
    #1;
    check("wait_req", {31'd0, imem_req}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: req=%0d addr=%08h valid=%0d ppf=%08h inst=%08h",
             imem_req, imem_addr, inst_valid, pc_plus_four, inst);
    check("arst_req",   {31'd0, imem_req}, 32'd0);
    check("arst_addr",  imem_addr, 32'h8000_0000);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_inst",  inst, INST_NOP);
    check("arst_ppf",   pc_plus_four, 32'h8000_0004);
    lat = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("arel_req",  {31'd0, imem_req}, 32'd1);
    check("arel_addr", imem_addr, 32'h8000_0000);

    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #1;
      if (inst_valid) found = 1'b1;
    end
    check("arel_seen", {31'd0, found}, 32'd1);
    if (found) begin
      $display("after reset: ppf=%08h inst=%08h", pc_plus_four, inst);
      check("arel_ppf",  pc_plus_four, 32'h8000_0004);
      check("arel_inst", inst, mem_word(32'h8000_0000));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
